// File: rtl/nnlayer_mul_pkg.sv
// Shared constants and tag payload for the nnlayer multiplier arbiter.
package nnlayer_mul_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = $clog2(NUM_REQ);
  localparam int unsigned DATA_W  = 14;
  localparam int unsigned MUL_LAT = 4;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

  // Requester index reached by stepping off places past base, wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base,
                                             input int unsigned     off);
    return ID_W'((32'(base) + off) % NUM_REQ);
  endfunction

endpackage

// File: rtl/nnlayer_rr_arbiter.sv
// Round-robin grant over NUM_REQ requests; search starts one past the last winner.
module nnlayer_rr_arbiter
  import nnlayer_mul_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [ID_W-1:0]    grant_id_c
);

  logic [ID_W-1:0] ptr;
  logic            found_c;

  always_comb begin
    grant_c    = '0;
    grant_id_c = '0;
    found_c    = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (en && !found_c && req[rr_idx(ptr, i)]) begin
        found_c                   = 1'b1;
        grant_c[rr_idx(ptr, i)]   = 1'b1;
        grant_id_c                = rr_idx(ptr, i);
      end
    end
  end

  // Pointer remembers the last winner so it gets lowest priority next time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= ID_W'(NUM_REQ - 1);
    end else if (found_c) begin
      ptr <= grant_id_c;
    end
  end

endmodule

// File: rtl/nnlayer_mul_arbiter.sv
// Shares one pipelined multiplier between NUM_REQ requesters; a tag pipeline
// tracks each product and response backpressure freezes the whole multiplier.
module nnlayer_mul_arbiter
  import nnlayer_mul_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      mul_ce,
  output logic [DATA_W-1:0]         mul_din0,
  output logic [DATA_W-1:0]         mul_din1,
  input  logic [DATA_W-1:0]         mul_dout,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  tag_t            tag_q [MUL_LAT];
  logic            issue_c;
  logic [ID_W-1:0] gid_c;

  assign rsp_valid = tag_q[MUL_LAT-1].v;
  assign rsp_id    = tag_q[MUL_LAT-1].id;
  assign rsp_data  = mul_dout;
  assign mul_ce    = ~(rsp_valid & ~rsp_ready);

  // Grants are suppressed while stalled and while reset is held.
  nnlayer_rr_arbiter u_arb (
    .clk        (clk),
    .reset      (reset),
    .en         (mul_ce & reset),
    .req        (req_valid),
    .grant_c    (req_ready),
    .grant_id_c (gid_c)
  );

  assign issue_c = |req_ready;

  // One-hot grant selects the operand pair; zero when nothing issues.
  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        mul_din0 = req_a[i*DATA_W +: DATA_W];
        mul_din1 = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Tag pipeline advances in lockstep with the multiplier clock-enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < MUL_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else if (mul_ce) begin
      tag_q[0].v  <= issue_c;
      tag_q[0].id <= gid_c;
      for (int unsigned s = 1; s < MUL_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned s = 0; s < MUL_LAT; s++) begin
      busy = busy | tag_q[s].v;
    end
  end

endmodule

// File: tb/tb_nnlayer_mul_arbiter.sv
// Directed and scoreboarded bench for nnlayer_mul_arbiter with a 4-stage multiplier model.
module tb_nnlayer_mul_arbiter;
  import nnlayer_mul_pkg::*;

  localparam int unsigned PW = 2 * DATA_W;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      mul_ce;
  logic [DATA_W-1:0]         mul_din0;
  logic [DATA_W-1:0]         mul_din1;
  logic [DATA_W-1:0]         mul_dout;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;

  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];
  logic [DATA_W-1:0] mpipe [MUL_LAT];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                id;
    logic [DATA_W-1:0] prod;
    int                cyc;
    int                stalls;
  } sb_t;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_a[g*DATA_W +: DATA_W] = a_arr[g];
    assign req_b[g*DATA_W +: DATA_W] = b_arr[g];
  end

  function automatic logic [DATA_W-1:0] trunc_mul(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'($signed(a)) * PW'($signed(b));
    return p[DATA_W-1:0];
  endfunction

  // External pipelined multiplier stand-in: MUL_LAT ce-gated stages, no reset.
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= trunc_mul(mul_din0, mul_din1);
      for (int s = 1; s < MUL_LAT; s++) mpipe[s] <= mpipe[s-1];
    end
  end
  assign mul_dout = mpipe[MUL_LAT-1];

  nnlayer_mul_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_ce    (mul_ce),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic pulse_reset();
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    reset     = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (mul_ce !== 1'b1) begin errors++; $display("FAIL reset_mul_ce: got %b want 1", mul_ce); end
    end
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_release: busy %b rsp_valid %b want 0 0", busy, rsp_valid); end
  endtask

  task automatic test_single();
    @(negedge clk);
    a_arr[2]  = 14'd7;
    b_arr[2]  = 14'h3FFD;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    checks++; if (mul_din0 !== 14'd7 || mul_din1 !== 14'h3FFD) begin errors++; $display("FAIL single_din: got %h %h want 0007 3ffd", mul_din0, mul_din1); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++; if (rsp_valid !== (k == 4)) begin errors++; $display("FAIL single_valid_c%0d: got %b want %b", k, rsp_valid, (k == 4)); end
      checks++; if (busy !== (k <= 4)) begin errors++; $display("FAIL single_busy_c%0d: got %b want %b", k, busy, (k <= 4)); end
      if (k == 4) begin
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", rsp_id); end
        checks++; if (rsp_data !== 14'h3FEB) begin errors++; $display("FAIL single_data: got %h want 3feb", rsp_data); end
      end
    end
  endtask

  task automatic test_fairness();
    logic [DATA_W-1:0] fair_prod [NUM_REQ];
    fair_prod = '{14'h3FF6, 14'h3FEE, 14'h3FE4, 14'h3FD8};
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = DATA_W'(i + 2);
      b_arr[i] = DATA_W'(-(i + 5));
    end
    pulse_reset();
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      req_valid = (c < 12) ? '1 : '0;
      #1;
      if (c < 12) begin
        checks++; if (req_ready !== (NUM_REQ'(1) << (c % NUM_REQ))) begin errors++; $display("FAIL fair_grant_c%0d: got %b want %b", c, req_ready, NUM_REQ'(1) << (c % NUM_REQ)); end
      end
      if (c >= 4 && c < 16) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== ID_W'((c - 4) % NUM_REQ) || rsp_data !== fair_prod[(c - 4) % NUM_REQ]) begin
          errors++; $display("FAIL fair_rsp_c%0d: got v%b id%0d %h want v1 id%0d %h", c, rsp_valid, rsp_id, rsp_data, (c - 4) % NUM_REQ, fair_prod[(c - 4) % NUM_REQ]);
        end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fair_idle_c%0d: got rsp_valid %b want 0", c, rsp_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    int                nxt = 0;
    int                got = 0;
    logic [DATA_W-1:0] held = '0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      @(negedge clk);
      rsp_ready = !(c >= 4 && c <= 6);
      if (nxt < 6) begin
        a_arr[1]  = DATA_W'(nxt);
        b_arr[1]  = 14'd3;
        req_valid = 4'b0010;
      end else begin
        req_valid = '0;
      end
      #1;
      if (c >= 4 && c <= 6) begin
        checks++; if (mul_ce !== 1'b0 || req_ready !== '0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_c%0d: got ce %b ready %b v %b want 0 0000 1", c, mul_ce, req_ready, rsp_valid); end
        if (c > 4) begin
          checks++; if (rsp_data !== held) begin errors++; $display("FAIL bp_hold_c%0d: got %h want %h", c, rsp_data, held); end
        end
        held = rsp_data;
      end else if (nxt < 6) begin
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready_c%0d: got %b want 0010", c, req_ready); end
      end
      if (rsp_valid && rsp_ready) begin
        checks++; if (rsp_id !== 2'd1 || rsp_data !== DATA_W'(3 * got)) begin errors++; $display("FAIL bp_item%0d: got id%0d %h want id1 %h", got, rsp_id, rsp_data, DATA_W'(3 * got)); end
        got++;
      end
      if (req_ready[1]) nxt++;
    end
    checks++; if (got != 6 || nxt != 6) begin errors++; $display("FAIL bp_count: got %0d issued %0d want 6 6", got, nxt); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_drain: got v%b busy%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_truncation();
    int lat  = 0;
    bit seen = 1'b0;
    @(negedge clk);
    a_arr[0]  = 14'h2000;
    b_arr[0]  = 14'h3FFF;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL trunc_ready: got %b want 0001", req_ready); end
    while (!seen && lat < 10) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      lat++;
      seen = rsp_valid;
    end
    checks++; if (!seen || lat != 4) begin errors++; $display("FAIL trunc_latency: got seen %b lat %0d want 1 4", seen, lat); end
    checks++; if (rsp_data !== 14'h2000 || rsp_id !== 2'd0) begin errors++; $display("FAIL trunc_data: got id%0d %h want id0 2000", rsp_id, rsp_data); end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_arr[3]  = DATA_W'(k + 1);
      b_arr[3]  = 14'd5;
      req_valid = 4'b1000;
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rmf_issue%0d: got %b want 1000", k, req_ready); end
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmf_busy_before: got %b want 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || mul_ce !== 1'b1) begin errors++; $display("FAIL rmf_clear: got v%b busy%b ce%b want 0 0 1", rsp_valid, busy, mul_ce); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = DATA_W'(i + 1);
      b_arr[i] = 14'd2;
    end
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmf_first_grant: got %b want 0001", req_ready); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++; if (rsp_valid !== (k == 4)) begin errors++; $display("FAIL rmf_valid_c%0d: got %b want %b", k, rsp_valid, (k == 4)); end
      if (k == 4) begin
        checks++; if (rsp_id !== 2'd0 || rsp_data !== 14'd2) begin errors++; $display("FAIL rmf_rsp: got id%0d %h want id0 0002", rsp_id, rsp_data); end
      end
    end
  endtask

  task automatic test_idle_gaps();
    sb_t                sb[$];
    sb_t                e;
    logic [NUM_REQ-1:0] acc = '0;
    int                 stall_cnt = 0;
    int                 lat;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      req_valid = req_valid & ~acc;
      if (c < 400) begin
        rsp_ready = ($urandom_range(3) != 0);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!req_valid[ID_W'(i)] && $urandom_range(7) == 0) begin
            a_arr[i] = DATA_W'($urandom);
            b_arr[i] = DATA_W'($urandom);
            req_valid[ID_W'(i)] = 1'b1;
          end
        end
      end else begin
        rsp_ready = 1'b1;
      end
      #1;
      checks++; if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin errors++; $display("FAIL gaps_grant_c%0d: got ready %b valid %b", c, req_ready, req_valid); end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL gaps_spurious_c%0d: got id%0d %h want none", c, rsp_id, rsp_data);
        end else begin
          e   = sb.pop_front();
          lat = c - e.cyc - (stall_cnt - e.stalls);
          if (rsp_id !== ID_W'(e.id) || rsp_data !== e.prod || lat != MUL_LAT) begin
            errors++; $display("FAIL gaps_rsp_c%0d: got id%0d %h lat%0d want id%0d %h lat%0d", c, rsp_id, rsp_data, lat, e.id, e.prod, MUL_LAT);
          end
        end
      end
      if (rsp_valid && !rsp_ready) stall_cnt++;
      acc = req_ready & req_valid;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[ID_W'(i)]) sb.push_back('{i, trunc_mul(a_arr[i], b_arr[i]), c, stall_cnt});
      end
    end
    checks++; if (sb.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL gaps_drain: got %0d pending busy %b want 0 0", sb.size(), busy); end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_truncation();
    test_reset_midflight();
    test_idle_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
